// File: rtl/array_ser_pkg.sv
// Shared types and helpers for the array row serializer.
package array_ser_pkg;

  typedef enum logic {
    StIdle,
    StSend
  } state_e;

  // Limit a requested row count to the number of rows a word holds.
  function automatic int unsigned clamp_rows(input int unsigned n, input int unsigned d1);
    return (n > d1) ? d1 : n;
  endfunction

endpackage

// File: rtl/unflatten_2d_array.sv
// Splits a flattened row-major word into D1 rows of D2 bits (row i at [i*D2 +: D2]).
module unflatten_2d_array #(
  parameter int unsigned D1 = 8,
  parameter int unsigned D2 = 4
) (
  input  logic [D1*D2-1:0]       array_1d,
  output logic [D1-1:0][D2-1:0]  array_2d
);

  // Pure rewiring of the flat bus into indexed rows.
  always_comb begin
    array_2d = '0;
    for (int i = 0; i < int'(D1); i++) begin
      array_2d[i] = array_1d[i*D2 +: D2];
    end
  end

endmodule

// File: rtl/array_row_serializer.sv
// Accepts one flattened D1xD2 word and streams its rows out one per beat.
module array_row_serializer
  import array_ser_pkg::*;
#(
  parameter int unsigned D1        = 8,
  parameter int unsigned D2        = 4,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned IW       = $clog2(D1),
  localparam int unsigned NW       = $clog2(D1 + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D1*D2-1:0] in_array_1d,
  input  logic [NW-1:0]    in_num_rows,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D2-1:0]    out_row,
  output logic [IW-1:0]    out_idx,
  output logic             out_last,
  output logic             busy
);

  state_e                state_q, state_d;
  logic [D1*D2-1:0]      word_q, word_d;
  logic [NW-1:0]         n_q, n_d;
  logic [NW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NW-1:0]         n_in;
  logic [IW-1:0]         start_idx;
  logic [D1-1:0][D2-1:0] rows;
  logic                  send, last, in_fire, out_fire;

  unflatten_2d_array #(
    .D1 (D1),
    .D2 (D2)
  ) u_unflatten (
    .array_1d (word_q),
    .array_2d (rows)
  );

  // Handshake decode and output drive; outputs read as zero outside SEND.
  always_comb begin
    n_in      = NW'(clamp_rows(32'(in_num_rows), D1));
    start_idx = MSB_FIRST ? IW'(n_in - NW'(1)) : '0;
    send      = (state_q == StSend);
    last      = send && (cnt_q == n_q - NW'(1));
    out_fire  = send && out_ready;
    // The last accepted beat frees the holding register in the same cycle.
    in_ready  = !flush && (!send || (last && out_ready));
    in_fire   = in_valid && in_ready;
    out_valid = send;
    busy      = send;
    out_last  = last;
    out_idx   = send ? idx_q : '0;
    out_row   = send ? rows[idx_q] : '0;
  end

  // Next-state: load on accept, step on each beat, flush wins over everything.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (flush) begin
      state_d = StIdle;
      n_d     = '0;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A zero-row word is consumed without emitting anything.
          if (in_fire && (n_in != '0)) begin
            state_d = StSend;
            word_d  = in_array_1d;
            n_d     = n_in;
            cnt_d   = '0;
            idx_d   = start_idx;
          end
        end
        StSend: begin
          if (out_fire) begin
            if (!last) begin
              idx_d = MSB_FIRST ? idx_q - IW'(1) : idx_q + IW'(1);
              cnt_d = cnt_q + NW'(1);
            end else if (in_fire && (n_in != '0)) begin
              word_d = in_array_1d;
              n_d    = n_in;
              cnt_d  = '0;
              idx_d  = start_idx;
            end else begin
              state_d = StIdle;
              n_d     = '0;
              cnt_d   = '0;
              idx_d   = '0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and holding registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      word_q  <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

endmodule
